// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer: explicit-select or round-robin arbitration, valid/ready on all sides.
// Define MUX_ARB_XFER_CNT_EN to add the saturating output-handshake counter (xfer_cnt, cnt_clr).
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_ARB_XFER_CNT_EN
    ,
    input  logic               cnt_clr,
    output logic [15:0]        xfer_cnt
`endif
);

    logic [N-1:0]     grant_sel;
    logic [N-1:0]     grant_rr;
    logic [N-1:0]     grant;
    logic [N-1:0]     above_last;
    logic             past_last;
    logic             found_hi;
    logic             found_lo;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] src_d;
    logic [SEL_W-1:0] src_q;
    logic [SEL_W-1:0] rr_last_q;
    logic             valid_q;

    // Equality-only compare so an out-of-range sel (N not a power of two) grants nothing.
    always_comb begin
        grant_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                grant_sel[i] = in_valid[i];
            end
        end
    end

    always_comb begin
        above_last = '0;
        past_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            above_last[i] = past_last;
            if (rr_last_q == SEL_W'(i)) begin
                past_last = 1'b1;
            end
        end
    end

    // Channels above rr_last take priority, then the scan wraps to channel 0.
    always_comb begin
        grant_rr = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_hi && in_valid[i] && above_last[i]) begin
                grant_rr[i] = 1'b1;
                found_hi    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_hi && !found_lo && in_valid[i] && !above_last[i]) begin
                grant_rr[i] = 1'b1;
                found_lo    = 1'b1;
            end
        end
    end

    assign grant    = mode ? grant_rr : grant_sel;
    assign can_load = !valid_q || out_ready;
    assign in_ready = grant & {N{can_load & rst_n}};
    assign xfer     = |in_ready;

    // grant is one-hot, so an OR-reduction mux is sufficient.
    always_comb begin
        data_d = '0;
        src_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_d = data_d | in_data[i*WIDTH +: WIDTH];
                src_d  = src_d | SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            src_q     <= '0;
            rr_last_q <= SEL_W'(N - 1);
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            src_q   <= src_d;
            if (mode) begin
                rr_last_q <= src_d;
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

`ifdef MUX_ARB_XFER_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (valid_q && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: a 4-channel instance for the main behaviour, a 3-channel one for out-of-range sel.
module tb_mux_arb_n;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  ch [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic [31:0]  c3 [3];
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic [1:0]   out_src3;
    logic         out_valid3;
    logic         out_ready3;
`ifdef MUX_ARB_XFER_CNT_EN
    logic         cnt_clr;
    logic         cnt_clr3;
    logic [15:0]  xfer_cnt;
    logic [15:0]  xfer_cnt3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign in_data  = {ch[3], ch[2], ch[1], ch[0]};
    assign in_data3 = {c3[2], c3[1], c3[0]};

    mux_arb_n #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_ARB_XFER_CNT_EN
        , .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
`endif
    );

    mux_arb_n #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
        .out_ready(out_ready3)
`ifdef MUX_ARB_XFER_CNT_EN
        , .cnt_clr(cnt_clr3), .xfer_cnt(xfer_cnt3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 4'hF; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_tests++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", out_src); end
        n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        n_tests++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready3: got %b expected 000", in_ready3); end
`ifdef MUX_ARB_XFER_CNT_EN
        n_tests++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
`endif
        in_valid = 4'h0; in_valid3 = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_explicit();
        ch[2] = 32'hDEAD_BEEF;
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel2_ready: got %b expected 0100", in_ready); end
        tick();
        n_tests++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sel2_data: got %h expected deadbeef", out_data); end
        n_tests++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL sel2_src: got %0d expected 2", out_src); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sel2_valid: got %b expected 1", out_valid); end
        sel = 2'd0; in_valid = 4'b1110;
        #1;
        n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL sel_idle_ready: got %b expected 0000", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL consume_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL consume_hold: got %h expected deadbeef", out_data); end
        sel = 2'd1; in_valid = 4'b0010;
        #1;
        n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL sel1_ready: got %b expected 0010", in_ready); end
        tick();
        n_tests++; if (out_data !== 32'hA000_0001) begin n_fail++; $display("FAIL sel1_data: got %h expected a0000001", out_data); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sel_out_of_range();
        logic [2:0] exp3;
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        n_tests++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL oor_ready: got %b expected 000", in_ready3); end
        tick();
        n_tests++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor_valid: got %b expected 0", out_valid3); end
        sel3 = 2'd2;
        #1;
        n_tests++; if (in_ready3 !== 3'b100) begin n_fail++; $display("FAIL n3_sel2_ready: got %b expected 100", in_ready3); end
        tick();
        n_tests++; if (out_data3 !== 32'hC000_0002) begin n_fail++; $display("FAIL n3_sel2_data: got %h expected c0000002", out_data3); end
        mode3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp3 = 3'b001 << (k % 3);
            #1;
            n_tests++; if (in_ready3 !== exp3) begin n_fail++; $display("FAIL n3_rr_ready[%0d]: got %b expected %b", k, in_ready3, exp3); end
            tick();
            n_tests++; if (out_src3 !== 2'(k % 3)) begin n_fail++; $display("FAIL n3_rr_src[%0d]: got %0d expected %0d", k, out_src3, k % 3); end
        end
        in_valid3 = 3'b000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = 4'b0001 << (k % 4);
            #1;
            n_tests++; if (in_ready !== exp) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, exp); end
            tick();
            n_tests++; if (out_src !== 2'(k % 4) || out_data !== ch[k % 4] || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL rr_out[%0d]: got src %0d data %h expected src %0d data %h", k, out_src, out_data, k % 4, ch[k % 4]);
            end
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (out_src !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
                n_fail++; $display("FAIL rr_1010[%0d]: got %0d expected %0d", k, out_src, (k % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp;
        in_valid = 4'b1111; out_ready = 1'b0; mode = 1'b0; sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 0000", k, in_ready); end
            tick();
            n_tests++; if (out_data !== ch[3] || out_src !== 2'd3 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got src %0d data %h expected src 3 data %h", k, out_src, out_data, ch[3]);
            end
        end
        mode = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = 4'b0001 << k;
            #1;
            n_tests++; if (in_ready !== exp) begin n_fail++; $display("FAIL resume_ready[%0d]: got %b expected %b", k, in_ready, exp); end
            tick();
            n_tests++; if (out_src !== 2'(k) || out_data !== ch[k]) begin
                n_fail++; $display("FAIL resume_out[%0d]: got src %0d expected %0d", k, out_src, k);
            end
        end
    endtask

    task automatic test_consume_and_load();
        ch[1] = 32'h0000_0011; in_valid = 4'b0010; mode = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL cl_ready: got %b expected 0010", in_ready); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0011 || out_src !== 2'd1) begin
            n_fail++; $display("FAIL cl_out: got valid %b data %h src %0d expected 1 00000011 1", out_valid, out_data, out_src);
        end
        in_valid = 4'b0000;
        tick();
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0000_0011) begin
            n_fail++; $display("FAIL cl_drain: got valid %b data %h expected 0 00000011", out_valid, out_data);
        end
    endtask

    task automatic test_rr_idle_and_wrap();
        mode = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
        in_valid = 4'b0001;
        tick();
        n_tests++; if (out_src !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL idle_next: got src %0d expected 0", out_src); end
        in_valid = 4'b1001;
        tick();
        n_tests++; if (out_src !== 2'd3) begin n_fail++; $display("FAIL wrap_a: got %0d expected 3", out_src); end
        tick();
        n_tests++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL wrap_b: got %0d expected 0", out_src); end
        in_valid = 4'b0000;
        tick();
    endtask

`ifdef MUX_ARB_XFER_CNT_EN
    task automatic test_counter();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0000; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_tests++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", xfer_cnt); end
        in_valid = 4'b1111;
        repeat (5) tick();
        in_valid = 4'b0000;
        tick(); tick();
        n_tests++; if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL cnt_five: got %0d expected 5", xfer_cnt); end
        in_valid = 4'b1111;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_tests++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", xfer_cnt); end
        repeat (65534) @(posedge clk);
        #1;
        n_tests++; if (xfer_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL cnt_fffe: got %h expected fffe", xfer_cnt); end
        tick();
        n_tests++; if (xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_ffff: got %h expected ffff", xfer_cnt); end
        tick();
        n_tests++; if (xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat: got %h expected ffff", xfer_cnt); end
        in_valid = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_async_reset();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        tick();
        n_tests++; if (out_src !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_setup: got src %0d expected 1", out_src); end
        in_valid = 4'b1111; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            n_fail++; $display("FAIL ar_regs: got valid %b data %h src %0d expected 0 0 0", out_valid, out_data, out_src);
        end
        n_tests++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_in_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_rr_ptr: got %b expected 0001", in_ready); end
        tick();
        n_tests++; if (out_src !== 2'd0 || out_data !== ch[0]) begin n_fail++; $display("FAIL ar_first: got src %0d expected 0", out_src); end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        ch[0] = 32'hA000_0000; ch[1] = 32'hA000_0001; ch[2] = 32'hA000_0002; ch[3] = 32'hA000_0003;
        c3[0] = 32'hC000_0000; c3[1] = 32'hC000_0001; c3[2] = 32'hC000_0002;
`ifdef MUX_ARB_XFER_CNT_EN
        cnt_clr = 1'b0; cnt_clr3 = 1'b0;
`endif
        test_reset();
        test_explicit();
        test_sel_out_of_range();
        test_round_robin();
        test_back_pressure();
        test_consume_and_load();
        test_rr_idle_and_wrap();
`ifdef MUX_ARB_XFER_CNT_EN
        test_counter();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
